// File: rtl/mmio_controller_if.sv
// mmio_controller_if
//   Data-memory bus between the processor/wrapper side and the MMIO controller.
//   master : processor side (drives address/store data/enable, forwards RAM read data)
//   slave  : controller side (returns load data, gates the RAM write enable)
//   mem_addr  32  processor data address
//   mem_wdata 32  processor store data
//   mem_wren  1   processor store enable
//   ram_rdata 32  RAM read data
//   ram_wren  1   RAM write enable (suppressed inside the I/O window)
//   mem_rdata 32  load data back to the processor
interface mmio_controller_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wren;
  logic [31:0] ram_rdata;
  logic        ram_wren;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, mem_wdata, mem_wren, ram_rdata,
                  input  ram_wren, mem_rdata);
  modport slave  (input  mem_addr, mem_wdata, mem_wren, ram_rdata,
                  output ram_wren, mem_rdata);
endinterface

// File: rtl/mmio_controller.sv
// mmio_controller
//   Memory-mapped I/O block sitting between the processor data port and RAM.
//   Decodes an 8-word I/O window at ADDR_BASE, blocks RAM writes inside it,
//   synchronises switches, debounces four buttons into sticky press events,
//   and owns the LED register and a free-running 32-bit LFSR.
// Ports
//   clock    system clock, all state on posedge
//   reset    asynchronous, active-high
//   bus      mmio_controller_if.slave (address/data/enables to/from processor and RAM)
//   btn_raw  {BTNU,BTNL,BTND,BTNR}, asynchronous
//   sw_raw   slide switches, asynchronous
//   led      LED register
//   irq      event interrupt
// Build option
//   MMIO_IRQ_EN : adds irq_mask (offset 5) and a registered irq output;
//                 when undefined irq is tied 0 and offset 5 reads 0.
// Register map (word offset inside window)
//   0 sw_sync (RO)  1 led (RW)  2 evt (W1C)  3 btn_stable (RO)
//   4 lfsr (RW)     5 irq_mask (RW, optional)  6,7 read 0
module mmio_controller #(
  parameter logic [31:0] ADDR_BASE       = 32'd4096,
  parameter int          DEBOUNCE_CYCLES = 400000,
  parameter int          CNT_W           = 19
) (
  input  logic                clock,
  input  logic                reset,
  mmio_controller_if.slave    bus,
  input  logic [3:0]          btn_raw,
  input  logic [15:0]         sw_raw,
  output logic [15:0]         led,
  output logic                irq
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]             btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic [15:0]            sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [3:0]             stable_q, stable_d, evt_q, evt_d, evt_clr, rise;
  logic [3:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]            led_q, led_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic                   io_hit, io_wr;
  logic [2:0]             off;

  assign io_hit       = (bus.mem_addr[31:3] == ADDR_BASE[31:3]);
  assign off          = bus.mem_addr[2:0];
  assign io_wr        = bus.mem_wren & io_hit;
  assign bus.ram_wren = bus.mem_wren & ~io_hit;
  assign led          = led_q;

`ifdef MMIO_IRQ_EN
  logic [3:0] mask_q, mask_d;
  logic       irq_q, irq_d;
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    btn_meta_d = btn_raw;
    btn_sync_d = btn_meta_q;
    sw_meta_d  = sw_raw;
    sw_sync_d  = sw_meta_q;
    led_d      = led_q;
    evt_clr    = 4'b0;
    lfsr_d     = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
`ifdef MMIO_IRQ_EN
    mask_d     = mask_q;
`endif
    // Bus writes; a store to offset 4 replaces this cycle's LFSR advance.
    if (io_wr) begin
      case (off)
        3'd1: led_d   = bus.mem_wdata[15:0];
        3'd2: evt_clr = bus.mem_wdata[3:0];
        3'd4: lfsr_d  = (bus.mem_wdata == 32'h0) ? 32'h1 : bus.mem_wdata;
`ifdef MMIO_IRQ_EN
        3'd5: mask_d  = bus.mem_wdata[3:0];
`endif
        default: ;
      endcase
    end
    // Debounce: count while the synced input differs from the accepted
    // level; any return to the accepted level restarts the count.
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      rise[i]     = 1'b0;
      if (btn_sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = btn_sync_q[i];
          rise[i]     = btn_sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    // Set after clear so a press wins over a simultaneous W1C.
    evt_d = (evt_q & ~evt_clr) | rise;
`ifdef MMIO_IRQ_EN
    irq_d = |(evt_d & mask_q);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      evt_q      <= '0;
      led_q      <= '0;
      lfsr_q     <= 32'h1;
`ifdef MMIO_IRQ_EN
      mask_q     <= '0;
      irq_q      <= 1'b0;
`endif
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      evt_q      <= evt_d;
      led_q      <= led_d;
      lfsr_q     <= lfsr_d;
`ifdef MMIO_IRQ_EN
      mask_q     <= mask_d;
      irq_q      <= irq_d;
`endif
    end
  end

  always_comb begin
    bus.mem_rdata = bus.ram_rdata;
    if (io_hit) begin
      case (off)
        3'd0:    bus.mem_rdata = {16'b0, sw_sync_q};
        3'd1:    bus.mem_rdata = {16'b0, led_q};
        3'd2:    bus.mem_rdata = {28'b0, evt_q};
        3'd3:    bus.mem_rdata = {28'b0, stable_q};
        3'd4:    bus.mem_rdata = lfsr_q;
`ifdef MMIO_IRQ_EN
        3'd5:    bus.mem_rdata = {28'b0, mask_q};
`endif
        default: bus.mem_rdata = 32'h0;
      endcase
    end
  end
endmodule
